// File: rtl/eco_sweep_ctrl_if.sv
// Host/datapath signal bundle for eco_sweep_ctrl: run handshake, stimulus fan-out,
// golden/revised responses and run results. The host side is master, the controller is slave.
interface eco_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       const_sel;
    logic [4:0] vec_o;
    logic       const_o;
    logic [3:0] gold_i;
    logic [3:0] rev_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] mism_cnt;
    logic [5:0] first_vec;
    logic [3:0] first_diff;
    logic       first_valid;

    modport master (
        output start, abort, const_sel, gold_i, rev_i,
        input  vec_o, const_o, busy, done, pass, mism_cnt, first_vec, first_diff, first_valid
    );

    modport slave (
        input  start, abort, const_sel, gold_i, rev_i,
        output vec_o, const_o, busy, done, pass, mism_cnt, first_vec, first_diff, first_valid
    );
endinterface

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive-sweep controller comparing golden and revised ECO datapaths with LAT-cycle alignment.
// Optional feature macro ECO_CONST_SWEEP_EN: also sweeps the patch const bit (64 vectors instead of 32).
module eco_sweep_ctrl #(
    parameter int unsigned LAT           = 0,
    parameter bit          STOP_ON_FIRST = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    eco_sweep_ctrl_if.slave bus
);
`ifdef ECO_CONST_SWEEP_EN
    localparam int unsigned CW = 6;
`else
    localparam int unsigned CW = 5;
`endif
    localparam logic [CW-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    drain_q;
    logic          stop_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [6:0]    mism_q;
    logic [6:0]    mism_d;
    logic [5:0]    first_vec_q;
    logic [3:0]    first_diff_q;
    logic          first_valid_q;

    logic          cur_const;
    logic          cur_v;
    logic [5:0]    cur_tag;
    logic          cmp_v;
    logic [5:0]    cmp_tag;
    logic          abort_run;
    logic          hit;
    logic          stop_hit;

`ifdef ECO_CONST_SWEEP_EN
    assign cur_const = cnt_q[5];
`else
    logic const_q;
    assign cur_const = const_q;
`endif

    assign cur_v     = (state_q == DRIVE) && !stop_q;
    assign cur_tag   = {cur_const, cnt_q[4:0]};
    assign abort_run = bus.abort && (state_q != IDLE);
    assign hit       = cmp_v && !stop_q && !abort_run && (bus.gold_i != bus.rev_i);
    assign stop_hit  = STOP_ON_FIRST && hit;
    assign mism_d    = mism_q + {6'd0, hit};

    // Delay the presented vector's valid/tag so they line up with the datapath response.
    if (LAT == 0) begin : g_comb
        assign cmp_v   = cur_v;
        assign cmp_tag = cur_tag;
    end else begin : g_pipe
        logic [LAT-1:0] v_q;
        logic [5:0]     tag_q [LAT];
        logic           flush;

        assign flush = abort_run || stop_hit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= '0;
                for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
            end else begin
                v_q[0]   <= flush ? 1'b0 : cur_v;
                tag_q[0] <= cur_tag;
                for (int i = 1; i < LAT; i++) begin
                    v_q[i]   <= flush ? 1'b0 : v_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end

        assign cmp_v   = v_q[LAT-1];
        assign cmp_tag = tag_q[LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            drain_q       <= '0;
            stop_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            mism_q        <= '0;
            first_vec_q   <= '0;
            first_diff_q  <= '0;
            first_valid_q <= 1'b0;
`ifndef ECO_CONST_SWEEP_EN
            const_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // NOTE: these are non-blocking, so a later assignment in this block (start's clears) wins.
            if (hit) begin
                mism_q <= mism_d;
                if (!first_valid_q) begin
                    first_vec_q   <= cmp_tag;
                    first_diff_q  <= bus.gold_i ^ bus.rev_i;
                    first_valid_q <= 1'b1;
                end
            end

            if (abort_run) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
                stop_q  <= 1'b0;
            end else if (stop_hit) begin
                stop_q <= 1'b1;
            end else if (stop_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (mism_d == 7'd0);
                stop_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state_q       <= DRIVE;
                            busy_q        <= 1'b1;
                            cnt_q         <= '0;
                            pass_q        <= 1'b0;
                            mism_q        <= '0;
                            first_vec_q   <= '0;
                            first_diff_q  <= '0;
                            first_valid_q <= 1'b0;
`ifndef ECO_CONST_SWEEP_EN
                            const_q       <= bus.const_sel;
`endif
                        end
                    end
                    DRIVE: begin
                        if (cnt_q != LAST_VEC) begin
                            cnt_q <= cnt_q + CW'(1);
                        end else if (LAT > 0) begin
                            state_q <= DRAIN;
                            drain_q <= 3'(LAT - 1);
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mism_d == 7'd0);
                        end
                    end
                    DRAIN: begin
                        if (drain_q == 3'd0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mism_d == 7'd0);
                        end else begin
                            drain_q <= drain_q - 3'd1;
                        end
                    end
                    DONE: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.vec_o       = cnt_q[4:0];
    assign bus.const_o     = cur_const;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.mism_cnt    = mism_q;
    assign bus.first_vec   = first_vec_q;
    assign bus.first_diff  = first_diff_q;
    assign bus.first_valid = first_valid_q;
endmodule

// File: tb/tb_eco_sweep_ctrl.sv
// Scoreboard bench for eco_sweep_ctrl: three instances (LAT=0, LAT=3, STOP_ON_FIRST) run in lockstep
// against a vector-loop reference model; a monitor pops expected results on each done pulse.
`timescale 1ns/1ps
module tb_eco_sweep_ctrl;
`ifdef ECO_CONST_SWEEP_EN
    localparam int NV    = 64;
    localparam bit SWEEP = 1'b1;
`else
    localparam int NV    = 32;
    localparam bit SWEEP = 1'b0;
`endif
    localparam int NDUT = 3;

    typedef struct {
        int busy_cycles;
        int mism;
        int fvec;
        int fdiff;
        int fvalid;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       const_sel = 1'b0;
    logic       fault_en = 1'b0;
    logic [1:0] fault_bit = 2'd0;
    logic       fault_val = 1'b0;

    logic [NDUT-1:0] busy_a, done_a, pass_a, fvalid_a, const_a;
    logic [6:0]      mism_a  [NDUT];
    logic [5:0]      fvec_a  [NDUT];
    logic [3:0]      fdiff_a [NDUT];
    logic [4:0]      vec_a   [NDUT];

    exp_t exp_q [NDUT][$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(int g);
        return (g == 1) ? 3 : 0;
    endfunction

    function automatic bit stop_of(int g);
        return (g == 2);
    endfunction

    // Reference ECO datapath: {w1, w0, u1, u0} from const and {z, y1, y0, x1, x0}.
    function automatic logic [3:0] datapath(logic c, logic [4:0] v);
        logic u0, u1, w0, w1;
        u0 = v[0] & v[1];
        u1 = v[0] ^ v[2] ^ c;
        w0 = v[3] | v[4];
        w1 = (v[1] & v[3]) ^ c;
        return {w1, w0, u1, u0};
    endfunction

    function automatic logic [3:0] inject(logic [3:0] r, logic en, logic [1:0] b, logic val);
        logic [3:0] o;
        o = r;
        if (en) o[b] = val;
        return o;
    endfunction

    // Whole-run result from walking every vector of the sweep.
    function automatic exp_t model(int lat, bit stop, logic csel, logic fen, logic [1:0] fb, logic fv);
        exp_t       e;
        int         first_k;
        logic       c;
        logic [4:0] v;
        logic [3:0] g, r;
        e.busy_cycles = 0; e.mism = 0; e.fvec = 0; e.fdiff = 0; e.fvalid = 0; e.pass = 0;
        first_k = -1;
        for (int k = 0; k < NV; k++) begin
            c = SWEEP ? (k >= 32) : csel;
            v = 5'(k % 32);
            g = datapath(c, v);
            r = inject(g, fen, fb, fv);
            if (g != r) begin
                if (first_k < 0) begin
                    first_k  = k;
                    e.fvec   = {26'd0, c, v};
                    e.fdiff  = {28'd0, g ^ r};
                    e.fvalid = 1;
                end
                e.mism++;
            end
        end
        if (stop && first_k >= 0) begin
            e.mism        = 1;
            e.busy_cycles = first_k + lat + 2;
        end else begin
            e.busy_cycles = NV + lat;
        end
        e.pass = (e.mism == 0);
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LATG  = lat_of(g);
        localparam bit          STOPG = stop_of(g);

        eco_sweep_ctrl_if bus ();
        logic [5:0] stim;
        logic [3:0] gold;

        if (LATG == 0) begin : g_comb
            assign stim = {bus.const_o, bus.vec_o};
        end else begin : g_reg
            logic [5:0] sh [LATG];
            always @(posedge clk) begin
                sh[0] <= {bus.const_o, bus.vec_o};
                for (int i = 1; i < LATG; i++) sh[i] <= sh[i-1];
            end
            assign stim = sh[LATG-1];
        end

        assign gold          = datapath(stim[5], stim[4:0]);
        assign bus.start     = start;
        assign bus.abort     = abort;
        assign bus.const_sel = const_sel;
        assign bus.gold_i    = gold;
        assign bus.rev_i     = inject(gold, fault_en, fault_bit, fault_val);

        assign busy_a[g]   = bus.busy;
        assign done_a[g]   = bus.done;
        assign pass_a[g]   = bus.pass;
        assign fvalid_a[g] = bus.first_valid;
        assign const_a[g]  = bus.const_o;
        assign mism_a[g]   = bus.mism_cnt;
        assign fvec_a[g]   = bus.first_vec;
        assign fdiff_a[g]  = bus.first_diff;
        assign vec_a[g]    = bus.vec_o;

        eco_sweep_ctrl #(.LAT(LATG), .STOP_ON_FIRST(STOPG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Monitor: measures busy length and checks results whenever a done pulse appears.
    bit prev_busy [NDUT];
    int bcnt      [NDUT];
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < NDUT; g++) begin
            if (busy_a[g]) bcnt[g] = prev_busy[g] ? bcnt[g] + 1 : 1;
            prev_busy[g] = busy_a[g];
            if (done_a[g]) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("dut%0d_unexpected_done", g), int'(done_a[g]), 0);
                end else begin
                    e = exp_q[g].pop_front();
                    check($sformatf("dut%0d_busy_cycles", g), bcnt[g], e.busy_cycles);
                    check($sformatf("dut%0d_mism_cnt", g), int'(mism_a[g]), e.mism);
                    check($sformatf("dut%0d_pass", g), int'(pass_a[g]), e.pass);
                    check($sformatf("dut%0d_first_valid", g), int'(fvalid_a[g]), e.fvalid);
                    check($sformatf("dut%0d_first_vec", g), int'(fvec_a[g]), e.fvec);
                    check($sformatf("dut%0d_first_diff", g), int'(fdiff_a[g]), e.fdiff);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(logic csel, bit stop_only);
        for (int g = 0; g < NDUT; g++)
            if (!stop_only || stop_of(g))
                exp_q[g].push_back(model(lat_of(g), stop_of(g), csel, fault_en, fault_bit, fault_val));
    endtask

    task automatic wait_drained(string name);
        int waited;
        waited = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && waited < 400) begin
            tick();
            waited++;
        end
        check(name, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
        for (int g = 0; g < NDUT; g++) exp_q[g].delete();
    endtask

    task automatic run_sweep(logic csel, logic mid_start);
        tick();
        start     = 1'b1;
        const_sel = csel;
        push_expected(csel, 1'b0);
        tick();
        start     = mid_start;
        const_sel = ~csel;
        tick();
        start = 1'b0;
        wait_drained("run_complete");
        tick();
        tick();
    endtask

    task automatic start_only(logic csel);
        tick();
        start     = 1'b1;
        const_sel = csel;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_vec(int target);
        int n;
        n = 0;
        while (int'(vec_a[0]) != target && n < 200) begin
            tick();
            n++;
        end
        check("reach_vec", int'(vec_a[0]), target);
    endtask

    task automatic check_all_zero(string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_dut%0d_busy", tag, g), int'(busy_a[g]), 0);
            check($sformatf("%s_dut%0d_done", tag, g), int'(done_a[g]), 0);
            check($sformatf("%s_dut%0d_pass", tag, g), int'(pass_a[g]), 0);
            check($sformatf("%s_dut%0d_mism", tag, g), int'(mism_a[g]), 0);
            check($sformatf("%s_dut%0d_first_valid", tag, g), int'(fvalid_a[g]), 0);
            check($sformatf("%s_dut%0d_first_vec", tag, g), int'(fvec_a[g]), 0);
            check($sformatf("%s_dut%0d_first_diff", tag, g), int'(fdiff_a[g]), 0);
            check($sformatf("%s_dut%0d_vec", tag, g), int'(vec_a[g]), 0);
            check($sformatf("%s_dut%0d_const", tag, g), int'(const_a[g]), 0);
        end
    endtask

    initial begin
        logic saw_done;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Identical models, then the revised u0 stuck-at-0 fault (with an ignored mid-run start).
        fault_en = 1'b0;
        run_sweep(1'b0, 1'b0);
        fault_en  = 1'b1;
        fault_bit = 2'd0;
        fault_val = 1'b0;
        run_sweep(1'b0, 1'b1);

        // Randomized faults and const selections.
        for (int r = 0; r < 10; r++) begin
            fault_en  = ($urandom_range(0, 3) != 0);
            fault_bit = 2'($urandom_range(0, 3));
            fault_val = 1'($urandom_range(0, 1));
            run_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort at vector 10: back to IDLE, no done, pass cleared.
        fault_en = 1'b0;
        start_only(1'b1);
        wait_vec(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int g = 0; g < NDUT; g++) check($sformatf("abort_dut%0d_busy", g), int'(busy_a[g]), 0);
        saw_done = 1'b0;
        repeat (8) begin
            tick();
            saw_done = saw_done | (|done_a);
        end
        check("abort_no_done", int'(saw_done), 0);
        for (int g = 0; g < NDUT; g++) check($sformatf("abort_dut%0d_pass", g), int'(pass_a[g]), 0);

        // Abort and start together in IDLE: the run must not start.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        tick();
        for (int g = 0; g < NDUT; g++) check($sformatf("abort_start_dut%0d_busy", g), int'(busy_a[g]), 0);

        // Reset at vector 20 with partial mismatch results present; the early-stop instance finishes first.
        fault_en  = 1'b1;
        fault_bit = 2'd0;
        fault_val = 1'b0;
        push_expected(1'b1, 1'b1);
        start_only(1'b1);
        wait_vec(20);
        check("pre_reset_mism_nonzero", int'(mism_a[0] != 7'd0), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        check("stop_run_complete", exp_q[2].size(), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int g = 0; g < NDUT; g++) exp_q[g].delete();

        // A clean run after reset must behave normally.
        fault_en = 1'b0;
        run_sweep(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eco_sweep_ctrl.md
# eco_sweep_ctrl

Exhaustive-sweep controller for the 5-input/4-output ECO patch datapath (inputs x0, x1, y0, y1, z, plus the patch `const` bit; outputs u0, u1, w0, w1). It drives one stimulus vector per cycle into a golden and a revised instance of the datapath, which sit outside this block. It aligns their responses for a configurable latency and compares them. At the end of a run it reports a mismatch count and the first failing vector, under a start/busy/done handshake for the host test logic.

## Interface
- `LAT`, 0: response latency of both datapath instances in cycles (0 = combinational); range 0..7.
- `STOP_ON_FIRST`, 0: 1 = end the run at the first mismatch.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `abort` in 1: synchronous abort; returns to IDLE without a `done` pulse.
- `const_sel` in 1: value driven on `const_o` for the run when the sweep option is off.
- `vec_o` out 5: stimulus {z, y1, y0, x1, x0}, fanned out to both instances.
- `const_o` out 1: patch `const` bit, fanned out to both instances.
- `gold_i` in 4: golden response {w1, w0, u1, u0}.
- `rev_i` in 4: revised response {w1, w0, u1, u0}.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse when the results are final.
- `pass` out 1: the last completed run had zero mismatches.
- `mism_cnt` out 7: mismatching vectors in the last run.
- `first_vec` out 6: {const, z, y1, y0, x1, x0} of the first mismatch.
- `first_diff` out 4: `gold_i ^ rev_i` at the first mismatch.
- `first_valid` out 1: `first_vec`/`first_diff` hold a captured mismatch.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- **IDLE**:
  - `start` = 1 clears `mism_cnt`, `first_valid`, `first_vec`, `first_diff` and `pass`.
  - It latches `const_sel`, zeroes the vector counter and enters DRIVE.
- **DRIVE**:
  - The counter presents vector k in cycle k. `vec_o` = counter[4:0]; `const_o` is per Configuration.
  - After vector N−1 is presented: go to DRAIN if `LAT` > 0, otherwise go to DONE.
- **DRAIN**: `LAT` cycles with no new vectors; `vec_o` holds its last value.
- **DONE**:
  - `done` = 1 for one cycle; `pass` = (`mism_cnt` == 0).
  - Returns to IDLE.
- **Compare pipeline**:
  - A valid bit and a 6-bit vector tag are delayed `LAT` cycles.
  - When the delayed valid is set and `gold_i` != `rev_i`: `mism_cnt` += 1.
  - If `first_valid` = 0 at that point, capture the tag into `first_vec`, capture the XOR into `first_diff`, and set `first_valid`.
- **Counter width**: `mism_cnt` is 7 bits; the maximum is 64, so no saturation is needed.
- **STOP_ON_FIRST = 1**:
  - The first mismatch forces DONE in the next cycle.
  - In-flight compares are discarded, so `mism_cnt` = 1.
- **Boundary cases**:
  - `start` while not IDLE: ignored.
  - `abort` in any non-IDLE state: go to IDLE next cycle; flush the pipeline valids; keep partial results; `done` stays 0; `pass` = 0.
  - `abort` and `start` together in IDLE: `abort` wins; the run does not start.
  - `rst_n` low mid-run: every register returns to its reset value immediately; no `done` pulse.
- **Reset values**:
  - `vec_o`, `const_o`, `mism_cnt`, `first_vec`, `first_diff`: 0.
  - `busy`, `done`, `pass`, `first_valid`: 0.
  - FSM: IDLE.

## Timing
- `start` is sampled at edge E0.
- Vector k is on `vec_o` from edge E0+k.
- The response to vector k is sampled at edge E0+k+`LAT`+1.
- `busy` = 1 from E0 to E0+N+`LAT` exclusive. That is N+`LAT` cycles; DONE is not counted.
- `done` is high in the cycle following edge E0+N+`LAT`.
- Result outputs update no later than that same edge and hold until the next accepted `start`.
- The earliest next `start` is sampled at the edge after `done`.

## Configuration
- `ECO_CONST_SWEEP_EN`:
  - Defined: N = 64, the counter is 6 bits, and `const_o` = counter[5]. Both patch polarities are swept and `const_sel` is ignored.
  - Undefined: N = 32, the counter is 5 bits, and `const_o` = the value of `const_sel` latched at `start`. `first_vec[5]` = that latched value.

## Test plan
- **Identical models, macro off**: `LAT`=0, `const_sel`=0, `gold_i` = `rev_i` → `done` after 32 busy cycles; `pass`=1, `mism_cnt`=0, `first_valid`=0.
- **Revised u0 stuck at 0, macro off**: → `mism_cnt`=8, `first_vec`=6'h03, `first_diff`=4'b0001, `pass`=0.
- **Same fault, `ECO_CONST_SWEEP_EN` defined**: → `mism_cnt`=16, `first_vec`=6'h03, `done` after 64 busy cycles.
- **Pipelined models**: `LAT`=3 with registered models → tags align, `mism_cnt` is unchanged vs `LAT`=0, `busy` lasts 35 cycles (macro off).
- **Early stop**: `STOP_ON_FIRST`=1 with the u0 fault → `done` two cycles after vector 3 is presented; `mism_cnt`=1.
- **Control interruptions**: `start` pulsed mid-run is ignored. `abort` at vector 10 → IDLE, no `done`, `pass`=0. `rst_n` low at vector 20 → all outputs 0 asynchronously.
